dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter XLEN, default 32, sets data and address width; only 32 is supported.
REQ-002 Parameter DEPTH_WORDS, default 512, sets the number of 32-bit storage words.
REQ-003 Parameter LATENCY, default 2, legal range 1..15, sets the cycles from request acceptance to response valid.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 req_valid_i  in  1  initiator presents a request.
REQ-007 req_ready_o  out  1  responder can accept a request.
REQ-008 req_we_i  in  1  1 = write, 0 = read.
REQ-009 req_addr_i  in  32  byte address.
REQ-010 req_wdata_i  in  32  write data.
REQ-011 req_be_i  in  4  byte enables for writes; bit k covers bits 8k+7:8k.
REQ-012 rsp_valid_o  out  1  response available.
REQ-013 rsp_ready_i  in  1  initiator accepts the response.
REQ-014 rsp_rdata_o  out  32  read data; 0 for writes and errors.
REQ-015 rsp_err_o  out  1  request was misaligned or out of range.
REQ-016 txn_count_o  out  16  count of completed responses.

Function
REQ-017 FSM states are IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-018 Acceptance occurs on an edge where req_valid_i=1 and req_ready_o=1; at acceptance, we, addr, wdata and be are latched and the FSM enters WAIT.
REQ-019 WAIT SHALL last exactly LATENCY cycles, so that rsp_valid_o rises LATENCY cycles after the accepting edge; LATENCY=1 gives rsp_valid_o in the first cycle after acceptance.
REQ-020 The latched request's memory operation (write commit or read sample) SHALL occur on the WAIT->RESP edge.
REQ-021 A request is in error if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; error requests SHALL NOT access storage and SHALL return rsp_err_o=1 and rsp_rdata_o=0.
REQ-022 A write SHALL update only the bytes whose be bit is 1; be=0000 completes normally with no storage change.
REQ-023 A read SHALL return the full stored word, ignoring be.
REQ-024 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be held stable until an edge with rsp_ready_i=1; that edge returns the FSM to IDLE.
REQ-025 txn_count_o SHALL increment by 1 on each response handshake, including error responses, and wrap from 0xFFFF to 0x0000.
REQ-026 There is no request/response overlap: the next request can be accepted no earlier than the edge after the response handshake, and throughput is at most one transaction per LATENCY+2 cycles.
REQ-027 Requests presented while req_ready_o=0 SHALL be ignored and not queued.
REQ-028 rsp_valid_o SHALL be driven directly by a register, with no combinational path from any input.

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and txn_count_o=0.
REQ-030 Reset during WAIT SHALL discard the pending request; a pending write SHALL NOT be committed.
REQ-031 Reset during RESP SHALL drop the response without incrementing txn_count_o.
REQ-032 Storage contents are not cleared by reset; they are undefined until written.

Verification
REQ-033 Write 0xDEADBEEF to 0x10 with be=1111, then read 0x10, LATENCY=2 -> rsp_valid_o rises 2 cycles after each acceptance, read returns 0xDEADBEEF, txn_count_o=2.
REQ-034 Starting from 0xDEADBEEF at 0x10, write 0x11223344 with be=0101, then read 0x10 -> returns 0xDE22BE44.
REQ-035 Read 0x13 (misaligned) and read DEPTH_WORDS*4 (out of range) -> each returns rsp_err_o=1 and rdata=0, storage is unchanged, and txn_count_o increments for each.
REQ-036 Hold rsp_ready_i=0 for 5 cycles during RESP while toggling req_valid_i -> response stays stable, req_ready_o stays 0, no extra acceptance; handshake then returns to IDLE.
REQ-037 Write 0xAAAA5555 to 0x20 and assert rst_i during WAIT, then read 0x20 -> prior contents returned, not 0xAAAA5555; outputs are at reset values while rst_i=1.
REQ-038 Complete 65536 transactions, or preload the counter through a bench force -> txn_count_o wraps to 0x0000.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-ported data memory responder with a fixed-latency request/response handshake.
// Latency: rsp_valid_o rises LATENCY cycles after the accepting edge; one transaction per LATENCY+2 cycles at best.
// Backpressure: req_ready_o is high only while idle; the response is held stable until rsp_ready_i.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i / req_ready_o request handshake
//   req_we_i, req_addr_i,     request: write flag, byte address,
//   req_wdata_i, req_be_i       write data, byte enables
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_rdata_o, rsp_err_o    read data (0 for writes/errors), error flag
//   txn_count_o               completed-response counter, wraps at 16 bits
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2     // legal range 1..15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [3:0]      req_be_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [15:0]     txn_count_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [15:0]     txn_count_q, txn_count_d;

  // Storage is deliberately not reset so it can map onto a RAM macro.
  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            addr_err;
  logic [AW-1:0]   word_idx;
  logic            mem_wr;

  // Error check works on the latched address, so it only matters in WAIT.
  always_comb begin
    addr_err = (addr_q[1:0] != 2'b00) ||
               ({2'b00, addr_q[XLEN-1:2]} >= 32'(DEPTH_WORDS));
    word_idx = addr_q[AW+1:2];
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;
    mem_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          be_d        = req_be_i;
          // Counting down from LATENCY-1 makes WAIT last exactly LATENCY cycles.
          wait_cnt_d  = 4'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          // The memory operation happens on this WAIT->RESP edge only.
          mem_wr      = we_q && !addr_err;
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_rdata_d = (addr_err || we_q) ? '0 : mem_q[word_idx];
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
    end
  end

  // mem_wr is derived from state_q, which reset holds in IDLE, so a write
  // pending in WAIT can never commit while or after reset is applied.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign txn_count_o = txn_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a word/byte-level memory model with a transaction counter.
module tb_dmem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [15:0] txn_count_o;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .txn_count_o (txn_count_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: memory contents plus which bytes have ever been written.
  logic [31:0] mem_m   [DEPTH];
  logic [3:0]  known_m [DEPTH];
  logic [15:0] cnt_m;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 32'(DEPTH));
  endfunction

  // Present a request in IDLE; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    @(negedge clk_i);
    check(32'(req_ready_o), 32'd1, "ready_in_idle");
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = wd;
    req_be_i    = be;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Measure latency, check the response against the model, then apply the write.
  task automatic wait_rsp(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    int          lat;
    int          idx;
    logic [31:0] mask;
    lat = 0;
    while (!rsp_valid_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check(32'(lat), 32'(LAT), "latency");
    check(32'(rsp_err_o), 32'(is_err(a)), "rsp_err");
    check(32'(req_ready_o), 32'd0, "ready_in_resp");
    idx = int'(a / 4);
    if (is_err(a) || we) begin
      check(rsp_rdata_o, 32'd0, "rdata_zero");
    end else begin
      mask = {{8{known_m[idx][3]}}, {8{known_m[idx][2]}},
              {8{known_m[idx][1]}}, {8{known_m[idx][0]}}};
      if (mask != 32'd0) check(rsp_rdata_o & mask, mem_m[idx] & mask, "rdata");
    end
    if (we && !is_err(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_m[idx][8*b +: 8] = wd[8*b +: 8];
          known_m[idx][b]      = 1'b1;
        end
      end
    end
  endtask

  // Hold the response for 'hold' cycles while poking req_valid_i, then handshake.
  task automatic finish_rsp(input int hold);
    logic [31:0] rd_s;
    logic        er_s;
    rd_s = rsp_rdata_o;
    er_s = rsp_err_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      req_valid_i = ~req_valid_i;
      req_we_i    = 1'($urandom);
      req_addr_i  = $urandom_range(0, 63) * 4;
      req_wdata_i = $urandom;
      req_be_i    = 4'($urandom);
      @(posedge clk_i);
      #1;
      check(32'(rsp_valid_o), 32'd1, "hold_valid");
      check(rsp_rdata_o, rd_s, "hold_rdata");
      check(32'(rsp_err_o), 32'(er_s), "hold_err");
      check(32'(req_ready_o), 32'd0, "hold_ready");
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    cnt_m = cnt_m + 16'd1;
    check(32'(rsp_valid_o), 32'd0, "post_hs_valid");
    check(32'(req_ready_o), 32'd1, "post_hs_ready");
    check(32'(txn_count_o), 32'(cnt_m), "txn_count");
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold);
    issue(we, a, wd, be);
    wait_rsp(we, a, wd, be);
    finish_rsp(hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(32'(req_ready_o), 32'd1, {tag, "_ready"});
    check(32'(rsp_valid_o), 32'd0, {tag, "_valid"});
    check(rsp_rdata_o, 32'd0, {tag, "_rdata"});
    check(32'(rsp_err_o), 32'd0, {tag, "_err"});
    check(32'(txn_count_o), 32'd0, {tag, "_count"});
  endtask

  initial begin
    logic        we;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = 32'd0;
      known_m[i] = 4'd0;
    end
    cnt_m       = 16'd0;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = 32'd0;
    req_wdata_i = 32'd0;
    req_be_i    = 4'd0;
    rsp_ready_i = 1'b0;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Full write then read back.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
    issue(1'b0, 32'h10, 32'h0, 4'b0000);
    wait_rsp(1'b0, 32'h10, 32'h0, 4'b0000);
    check(rsp_rdata_o, 32'hDEADBEEF, "full_word_read");
    finish_rsp(0);
    check(32'(txn_count_o), 32'd2, "count_after_two");

    // Partial byte-enable write, then be=0000 write that must change nothing.
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    issue(1'b0, 32'h10, 32'h0, 4'b1010);
    wait_rsp(1'b0, 32'h10, 32'h0, 4'b1010);
    check(rsp_rdata_o, 32'hDE22BE44, "byte_enable_merge");
    finish_rsp(0);

    // Misaligned and out-of-range requests, including writes that would alias 0x10.
    txn(1'b0, 32'h13, 32'h0, 4'b1111, 0);
    txn(1'b0, 32'(DEPTH * 4), 32'h0, 4'b1111, 0);
    txn(1'b1, 32'h12, 32'h55555555, 4'b1111, 0);
    txn(1'b1, 32'(DEPTH * 4) + 32'h10, 32'h66666666, 4'b1111, 0);
    issue(1'b0, 32'h10, 32'h0, 4'b1111);
    wait_rsp(1'b0, 32'h10, 32'h0, 4'b1111);
    check(rsp_rdata_o, 32'hDE22BE44, "err_no_store_change");
    finish_rsp(0);

    // Response held off for 5 cycles with request noise on the input.
    txn(1'b0, 32'h10, 32'h0, 4'b1111, 5);
    @(posedge clk_i);
    #1;
    check(32'(rsp_valid_o), 32'd0, "no_extra_accept");

    // Reset while a write is in WAIT: the write must be dropped.
    txn(1'b1, 32'h20, 32'h01020304, 4'b1111, 0);
    issue(1'b1, 32'h20, 32'hAAAA5555, 4'b1111);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_in_wait");
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk_i);
    rst_i = 1'b0;
    cnt_m = 16'd0;
    issue(1'b0, 32'h20, 32'h0, 4'b1111);
    wait_rsp(1'b0, 32'h20, 32'h0, 4'b1111);
    check(rsp_rdata_o, 32'h01020304, "wait_write_dropped");
    finish_rsp(0);

    // Reset while in RESP: response dropped, counter not bumped.
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'b1111);
    wait_rsp(1'b1, 32'h30, 32'hCAFEF00D, 4'b1111);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_in_resp");
    @(negedge clk_i);
    rst_i = 1'b0;
    cnt_m = 16'd0;
    txn(1'b0, 32'h30, 32'h0, 4'b1111, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      we = 1'($urandom);
      if (r < 8)       a = $urandom_range(0, 15) * 4;
      else if (r == 8) a = ($urandom_range(0, 15) * 4) | $urandom_range(1, 3);
      else             a = 32'(DEPTH * 4) + $urandom_range(0, 1000) * 4;
      txn(we, a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // Counter wrap via preload.
    @(negedge clk_i);
    force dut.txn_count_q = 16'hFFFF;
    #1;
    release dut.txn_count_q;
    cnt_m = 16'hFFFF;
    check(32'(txn_count_o), 32'h0000FFFF, "count_preload");
    txn(1'b0, 32'h10, 32'h0, 4'b1111, 0);
    check(32'(txn_count_o), 32'h00000000, "count_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
